regs_mem_mp: RTL
================

Name: regs_mem_mp

Overview:
Parametrised multi-read-port register file memory for the picoMIPS datapath. It is the next generation of the fixed triple-port register store. Generalisations:
- configurable width, depth and read-port count
- optional write-to-read bypass
- optional hardwired zero register
- a hardware init sequencer that loads every register with the unity value after reset, instead of relying on power-up initialisation
- a per-port read-hold (stall) enable

Parameters:
WIDTH, 8, data width of each register in bits
DEPTH, 8, number of registers (need not be a power of two)
NRD, 2, number of read ports (1..8)
UNITY, 8, value loaded into every register by the init sequencer (1 << 3 with defaults, to account for the lower significance of immediates)
ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded
BYPASS, 1, when 1 a same-cycle write to a register being read is forwarded to q
AW, $clog2(DEPTH) (min 1), address width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
n_reset  input  1  asynchronous, active-low reset
we  input  1  write enable
wr_addr  input  AW  write address
d  input  WIDTH  write data
rd_addr  input  NRD*AW  packed read addresses; port i at [i*AW +: AW]
re  input  NRD  per-port read enable; 0 holds that port's q
q  output  NRD*WIDTH  packed registered read data; port i at [i*WIDTH +: WIDTH]
ready  output  1  high once the init sequence has completed

Behaviour:
- One clock domain. Reset is asynchronous and active-low (n_reset). All control state and outputs clear immediately on n_reset low.
- Reset values:
  - q = 0 on all ports
  - ready = 0
  - init counter = 0
  - FSM = INIT
  - Array contents are not reset directly; the sequencer rewrites them.
- FSM states:
  - INIT, then RUN. No other states.
- INIT:
  - Each clk writes UNITY to mem[cnt], then cnt increments.
  - When cnt = DEPTH-1 is written, go to RUN next cycle and assert ready.
  - INIT takes exactly DEPTH cycles after n_reset deasserts; ready rises on the edge at cycle DEPTH.
  - External we is ignored and q stays 0 throughout INIT.
  - With ZERO_REG=1, address 0 is still written; it is harmless because reads of 0 are forced to 0.
- RUN:
  - Remains in RUN until n_reset asserts. Reset mid-INIT or mid-RUN restarts INIT from cnt = 0 and drops ready asynchronously.
  - Write: if we, wr_addr < DEPTH, and not (ZERO_REG and wr_addr = 0), then mem[wr_addr] <= d on the rising edge. Otherwise the write is dropped.
  - Read: 1-cycle latency. If re[i], q[i] <= the value of mem[rd_addr[i]] before this edge's write.
  - Bypass: if BYPASS=1 and the same-cycle write is accepted to rd_addr[i], q[i] <= d instead.
  - If re[i]=0, q[i] holds its value regardless of writes, including to the held address.
  - Read address >= DEPTH gives q[i] <= 0.
  - ZERO_REG=1 and rd_addr[i]=0 gives q[i] <= 0, with no bypass even if we targets 0.
  - All read ports may address the same register simultaneously; each returns identical data.
- Widths: no arithmetic on data; d is stored unmodified. The init counter is AW bits and is compared against DEPTH-1, so a non-power-of-two DEPTH never wraps.

Test Plan:
- Defaults; release n_reset, idle 8 cycles -> ready rises on the 8th edge. Then rd_addr port0 = 3, port1 = 7, re = 11 -> both q = 8; reg 0 reads 0.
- Post-ready: we = 1, wr_addr = 5, d = 0xA5, with port0 reading 5 on the same cycle -> q0 = 0xA5 next cycle (BYPASS=1). Rerun with BYPASS=0 -> q0 = 0x08, then 0xA5 one cycle later.
- Write d = 0xFF to addr 0 with ZERO_REG=1 -> reads of 0 return 0x00. With ZERO_REG=0, the same write reads back 0xFF.
- re = 0 on port1 holding 0x08 from reg 2; write 0x33 to reg 2 -> q1 stays 0x08. Set re = 1 -> q1 = 0x33.
- DEPTH=6: read addr 7 -> q = 0; write addr 6 is dropped; init completes in 6 cycles.
- Assert n_reset at cycle 3 of INIT, then again in RUN after writing 0x5A to reg 4 -> q = 0 and ready = 0 immediately. After DEPTH cycles, reg 4 reads 0x08. A we pulse during INIT has no effect.

Source files
------------

// File: rtl/regs_mem_mp_if.sv
// ----------------------------------------------------------------------------
// regs_mem_mp_if
//   Bus bundle for the regs_mem_mp multi-read-port register file.
//
//   we       write enable
//   wr_addr  write address (AW bits)
//   d        write data (WIDTH bits)
//   rd_addr  packed read addresses, port i at [i*AW +: AW]
//   re       per-port read enable; 0 holds that port's q
//   q        packed registered read data, port i at [i*WIDTH +: WIDTH]
//   ready    high once the init sequence has loaded every register
//
//   master : the datapath driving the register file
//   slave  : the register file itself
// ----------------------------------------------------------------------------
interface regs_mem_mp_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int NRD   = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   we;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       d;
    logic [NRD*AW-1:0]      rd_addr;
    logic [NRD-1:0]         re;
    logic [NRD*WIDTH-1:0]   q;
    logic                   ready;

    modport master (
        output we, wr_addr, d, rd_addr, re,
        input  q, ready
    );

    modport slave (
        input  we, wr_addr, d, rd_addr, re,
        output q, ready
    );
endinterface

// File: rtl/regs_mem_mp.sv
// ----------------------------------------------------------------------------
// regs_mem_mp
//   Parametrised multi-read-port register file for the picoMIPS datapath.
//   After reset a sequencer writes UNITY into every register (one per clock),
//   then the block serves one write port and NRD registered read ports.
//
//   clk      rising-edge clock
//   n_reset  asynchronous active-low reset (restarts the init sequence)
//   bus      regs_mem_mp_if.slave: we, wr_addr, d, rd_addr, re -> q, ready
//
//   Parameters: WIDTH, DEPTH (any value >= 1), NRD (1..8), UNITY (init value),
//   ZERO_REG (register 0 reads as zero, writes to it dropped), BYPASS
//   (same-cycle accepted write forwarded to a port reading that register).
//   The interface instance must be built with the same WIDTH/DEPTH/NRD.
// ----------------------------------------------------------------------------
module regs_mem_mp #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int NRD      = 2,
    parameter int UNITY    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          n_reset,
    regs_mem_mp_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    LAST_C  = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] UNITY_C = WIDTH'(UNITY);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q;
    logic [AW-1:0]          cnt_q;
    logic                   ready_q;
    logic [NRD*WIDTH-1:0]   q_q;

    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic                   wr_ok;
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;
    logic [WIDTH-1:0]       rd_d [NRD];

    // External write acceptance and per-port next read value (RUN only).
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ok = bus.we
              && ({1'b0, bus.wr_addr} < DEPTH_C)
              && !((ZERO_REG != 0) && (bus.wr_addr == '0));

        for (int i = 0; i < NRD; i++) begin
            rd_d[i] = '0;
            if (({1'b0, bus.rd_addr[i*AW +: AW]} < DEPTH_C)
                && !((ZERO_REG != 0) && (bus.rd_addr[i*AW +: AW] == '0))) begin
                if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr[i*AW +: AW]))
                    rd_d[i] = bus.d;
                else
                    rd_d[i] = mem_q[bus.rd_addr[i*AW +: AW]];
            end
        end
    end

    // Single array write port shared by the init sequencer and the bus.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.d;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = UNITY_C;
        end else begin
            mem_we = wr_ok;
        end
    end

    // NOTE: the array has no reset; the init sequencer rewrites every entry after reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    // Control FSM with registered read data and ready.
    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!n_reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            q_q     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // Bus writes are ignored and q stays 0 while loading.
                    if (cnt_q == LAST_C) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NRD; i++) begin
                        if (bus.re[i])
                            q_q[i*WIDTH +: WIDTH] <= rd_d[i];
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.q     = q_q;
    assign bus.ready = ready_q;

endmodule
